// File: rtl/switch_debouncer.sv
// Slide-switch conditioner: two-flop synchroniser, shared sample-tick prescaler
// and per-bit stability counters producing a clean level vector plus change pulses.
module switch_debouncer #(
  parameter int WIDTH        = 18,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_changed,
  output logic             any_change,
  output logic             tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [PW-1:0]    presc_q;
  logic [PW-1:0]    presc_d;
  logic             tick_q;
  logic             tick_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] clean_q;
  logic [WIDTH-1:0] clean_d;
  logic [WIDTH-1:0] changed_q;
  logic [WIDTH-1:0] changed_d;
  logic             any_q;
  logic             any_d;

  // Synchroniser chain and prescaler registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= {WIDTH{1'b0}};
      sync2_q <= {WIDTH{1'b0}};
      presc_q <= {PW{1'b0}};
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  // Prescaler wraps at TICK_DIV-1; tick is the registered terminal-count flag.
  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (presc_q == PRESC_LAST) begin
      presc_d = {PW{1'b0}};
      tick_d  = 1'b1;
    end else begin
      presc_d = presc_q + PW'(1);
      tick_d  = 1'b0;
    end
  end

  // Per-bit stability evaluation; any return to the clean level restarts the count.
  always_comb begin
    clean_d   = clean_q;
    changed_d = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == clean_q[i]) begin
        cnt_d[i] = {CW{1'b0}};
      end else if (tick_q && (cnt_q[i] == CNT_LAST)) begin
        clean_d[i]   = sync2_q[i];
        changed_d[i] = 1'b1;
        cnt_d[i]     = {CW{1'b0}};
      end else if (tick_q) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
    any_d = |changed_d;
  end

  // Debounce state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= {CW{1'b0}};
      end
      clean_q   <= {WIDTH{1'b0}};
      changed_q <= {WIDTH{1'b0}};
      any_q     <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      clean_q   <= clean_d;
      changed_q <= changed_d;
      any_q     <= any_d;
    end
  end

  assign sw_clean   = clean_q;
  assign sw_changed = changed_q;
  assign any_change = any_q;
  assign tick       = tick_q;

endmodule
